// File: rtl/cpu_mem_arbiter.sv
// rtl/cpu_mem_arbiter.sv - merges CPU instruction-read, data-read and data-write requests onto one word SRAM
// Optional misaligned-access error output: CPU_MEM_ARB_MISALIGN_ERR_EN
module cpu_mem_arbiter #(
  parameter int MEM_AW = 14,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read_req,
  input  logic              i_read_w,
  input  logic              i_read_hw,
  input  logic [31:0]       i_read_adr,
  input  logic              d_read_req,
  input  logic              d_read_w,
  input  logic              d_read_hw,
  input  logic [31:0]       d_read_adr,
  input  logic              d_write_req,
  input  logic              d_write_w,
  input  logic              d_write_hw,
  input  logic [31:0]       d_write_adr,
  input  logic [31:0]       d_write_data,
  output logic              read_valid,
  output logic [31:0]       read_data,
  output logic              write_finish,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [MEM_AW-1:0] mem_adr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
`ifdef CPU_MEM_ARB_MISALIGN_ERR_EN
  ,
  output logic              bus_err
`endif
);

  typedef enum logic [2:0] {IDLE, RD_WAIT, WR, DONE, GAP} state_t;

  localparam logic [2:0] RD_LAST = 3'(RD_LAT);

  state_t              state, state_n;
  logic [2:0]          cnt, cnt_n;
  logic                sz_w, sz_w_n, sz_hw, sz_hw_n, err, err_n;
  logic [1:0]          lane, lane_n;
  logic                read_valid_n, write_finish_n, mem_en_n, mem_we_n;
  logic                err_pulse, err_pulse_n;
  logic [3:0]          mem_be_n;
  logic [MEM_AW-1:0]   mem_adr_n;
  logic [31:0]         mem_wdata_n, read_data_n;

  logic                any_req, sel_wr, sel_w, sel_hw, misalign;
  logic [31:0]         sel_adr;
  logic [4:0]          rd_shift;
  logic [31:0]         rd_shifted, rd_aligned;
  logic                unused_bits;

  // Fixed priority: write beats data read beats instruction read.
  always_comb begin
    sel_wr  = 1'b0;
    sel_w   = i_read_w;
    sel_hw  = i_read_hw;
    sel_adr = i_read_adr;
    if (d_write_req) begin
      sel_wr  = 1'b1;
      sel_w   = d_write_w;
      sel_hw  = d_write_hw;
      sel_adr = d_write_adr;
    end else if (d_read_req) begin
      sel_w   = d_read_w;
      sel_hw  = d_read_hw;
      sel_adr = d_read_adr;
    end
  end

  assign any_req = i_read_req | d_read_req | d_write_req;

`ifdef CPU_MEM_ARB_MISALIGN_ERR_EN
  assign misalign = sel_w ? (sel_adr[1:0] != 2'b00) : (sel_hw & sel_adr[0]);
  assign bus_err  = err_pulse;
`else
  assign misalign = 1'b0;
`endif

  assign unused_bits = ^{sel_adr[31:MEM_AW+2], err_pulse};

  always_comb begin
    rd_shift   = sz_w ? 5'd0 : (sz_hw ? {lane[1], 4'b0000} : {lane, 3'b000});
    rd_shifted = mem_rdata >> rd_shift;
    if (sz_w)       rd_aligned = rd_shifted;
    else if (sz_hw) rd_aligned = {16'h0000, rd_shifted[15:0]};
    else            rd_aligned = {24'h000000, rd_shifted[7:0]};
  end

  always_comb begin
    state_n        = state;
    cnt_n          = cnt;
    sz_w_n         = sz_w;
    sz_hw_n        = sz_hw;
    lane_n         = lane;
    err_n          = err;
    read_valid_n   = 1'b0;
    write_finish_n = 1'b0;
    err_pulse_n    = 1'b0;
    mem_en_n       = 1'b0;
    mem_we_n       = 1'b0;
    mem_be_n       = mem_be;
    mem_adr_n      = mem_adr;
    mem_wdata_n    = mem_wdata;
    read_data_n    = read_data;
    case (state)
      IDLE: begin
        if (any_req) begin
          sz_w_n    = sel_w;
          sz_hw_n   = sel_hw & ~sel_w;
          lane_n    = sel_adr[1:0];
          err_n     = misalign;
          cnt_n     = 3'd0;
          mem_en_n  = ~misalign;
          mem_we_n  = sel_wr & ~misalign;
          mem_adr_n = sel_adr[MEM_AW+1:2];
          if (sel_w)       mem_be_n = 4'b1111;
          else if (sel_hw) mem_be_n = sel_adr[1] ? 4'b1100 : 4'b0011;
          else             mem_be_n = 4'b0001 << sel_adr[1:0];
          if (sel_w)       mem_wdata_n = d_write_data;
          else if (sel_hw) mem_wdata_n = {2{d_write_data[15:0]}};
          else             mem_wdata_n = {4{d_write_data[7:0]}};
          state_n = sel_wr ? WR : RD_WAIT;
        end
      end
      RD_WAIT: begin
        // cnt==RD_LAT is the cycle the SRAM presents the data
        cnt_n = cnt + 3'd1;
        if (cnt == RD_LAST) begin
          read_valid_n = 1'b1;
          err_pulse_n  = err;
          read_data_n  = err ? 32'h0 : rd_aligned;
          state_n      = DONE;
        end
      end
      WR: begin
        cnt_n = cnt + 3'd1;
        if (cnt == 3'd1) begin
          write_finish_n = 1'b1;
          err_pulse_n    = err;
          state_n        = DONE;
        end
      end
      DONE:    state_n = GAP;
      GAP:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= 3'd0;
      sz_w         <= 1'b0;
      sz_hw        <= 1'b0;
      lane         <= 2'b00;
      err          <= 1'b0;
      read_valid   <= 1'b0;
      write_finish <= 1'b0;
      err_pulse    <= 1'b0;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_be       <= 4'b0000;
      mem_adr      <= '0;
      mem_wdata    <= 32'h0;
      read_data    <= 32'h0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      sz_w         <= sz_w_n;
      sz_hw        <= sz_hw_n;
      lane         <= lane_n;
      err          <= err_n;
      read_valid   <= read_valid_n;
      write_finish <= write_finish_n;
      err_pulse    <= err_pulse_n;
      mem_en       <= mem_en_n;
      mem_we       <= mem_we_n;
      mem_be       <= mem_be_n;
      mem_adr      <= mem_adr_n;
      mem_wdata    <= mem_wdata_n;
      read_data    <= read_data_n;
    end
  end

endmodule
